// File: rtl/mem_write_arbiter_if.sv
// Requester-side write bus and memory-register write port for mem_write_arbiter.
// The master modport is the requester/memory side. The slave modport is the arbiter.
interface mem_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 35
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               mem_wren;
    logic [DW-1:0]      mem_din;

    modport master (
        output req,
        output req_data,
        input  ack,
        input  mem_wren,
        input  mem_din
    );

    modport slave (
        input  req,
        input  req_data,
        output ack,
        output mem_wren,
        output mem_din
    );
endinterface

// File: rtl/mem_write_arbiter.sv
// Round-robin write arbiter for the shared 35-bit memory register.
// Each transaction runs IDLE -> WRITE -> ACK, so the block completes one write every three cycles.
// Only registered state drives the memory strobe and the ack, so there is no combinational path
// from req to mem_wren.
module mem_write_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 35
) (
    input  logic                 clk,
    input  logic                 arst,
    mem_write_arbiter_if.slave   bus,
    output logic                 busy,
    output logic [IDW-1:0]       last_id,
    output logic [15:0]          wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  sel;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  ptr_nx;
    logic            any_req;
    logic [DW-1:0]   data_q;

    // Pick the first requester at or above ptr, wrapping modulo NREQ.
    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel     = ptr;
        cand    = ptr;
        any_req = 1'b0;
        // Scan from the farthest offset down, so the nearest set bit is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (bus.req[cand]) begin
                sel     = cand;
                any_req = 1'b1;
            end
        end
        ptr_nx = (int'(sel) == NREQ - 1) ? '0 : sel + IDW'(1);
    end

    // State register. A reset aborts any transaction in flight.
    // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. Only IDLE waits; WRITE and ACK each last exactly one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = WRITE;
            WRITE:   state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the registered state: write strobe, one-hot ack, busy.
    always_comb begin
        bus.mem_wren = 1'b0;
        bus.ack      = '0;
        busy         = (state != IDLE);
        case (state)
            WRITE:   bus.mem_wren = 1'b1;
            ACK:     bus.ack[grant] = 1'b1;
            default: ;
        endcase
    end

    // Capture the winner, its record and the rotated pointer on the grant edge.
    // The captured record is cleared on reset because it drives mem_din directly.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr    <= '0;
            grant  <= '0;
            data_q <= '0;
        end else if (state == IDLE && any_req) begin
            grant  <= sel;
            data_q <= bus.req_data[int'(sel) * DW +: DW];
            ptr    <= ptr_nx;
        end
    end

    assign bus.mem_din = data_q;

    // Status registers update on the same edge that the memory register captures mem_din.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            last_id  <= '0;
            wr_count <= '0;
        end else if (state == WRITE) begin
            last_id <= grant;
            if (wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter.
// The reference model tracks each transaction as a grant followed by two cycles: a write, then an ack.
// The bench also holds the external memory register that the arbiter writes into.
module tb_mem_write_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 35;

    logic           clk = 1'b0;
    logic           arst = 1'b0;
    logic           busy;
    logic [IDW-1:0] last_id;
    logic [15:0]    wr_count;
    logic [DW-1:0]  mem_q;

    always #5 clk = ~clk;

    mem_write_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    mem_write_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) dut (
        .clk      (clk),
        .arst     (arst),
        .bus      (bus),
        .busy     (busy),
        .last_id  (last_id),
        .wr_count (wr_count)
    );

    // External memory register, cleared by the same reset.
    always @(posedge clk or posedge arst) begin
        if (arst) mem_q <= '0;
        else if (bus.mem_wren) mem_q <= bus.mem_din;
    end

    // Reference model state.
    int              m_left;    // cycles left in the current transaction (2 = write, 1 = ack, 0 = none)
    int              m_ptr;
    int              m_grant;
    int              m_last;
    logic [DW-1:0]   m_data;
    logic [DW-1:0]   m_mem;
    logic [15:0]     m_count;

    // Observation counters.
    int              n_checks = 0;
    int              n_fail = 0;
    int              wren_seen;
    int              ack_seen [NREQ];
    int              ack_log [$];
    bit              auto_drop;
    bit              rand_mode;
    logic [NREQ-1:0] req_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_ptr   = 0;
        m_grant = 0;
        m_last  = 0;
        m_data  = '0;
        m_mem   = '0;
        m_count = '0;
    endtask

    task automatic clear_stats();
        wren_seen = 0;
        for (int i = 0; i < NREQ; i++) ack_seen[i] = 0;
        ack_log.delete();
    endtask

    // Apply one rising edge to the model, using the inputs that are stable across the edge.
    task automatic model_edge();
        if (arst) return;
        if (m_left == 2) begin
            m_mem  = m_data;
            m_last = m_grant;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            m_left = 1;
        end else if (m_left == 1) begin
            m_left = 0;
        end else if (bus.req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (bus.req[(m_ptr + k) % NREQ]) begin
                    m_grant = (m_ptr + k) % NREQ;
                    break;
                end
            end
            m_data = bus.req_data[m_grant * DW +: DW];
            m_ptr  = (m_grant + 1) % NREQ;
            m_left = 2;
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] eack;
        eack = (m_left == 1) ? NREQ'(1 << m_grant) : '0;
        check("mem_wren", 64'(bus.mem_wren), 64'(m_left == 2));
        check("ack",      64'(bus.ack),      64'(eack));
        check("busy",     64'(busy),         64'(m_left != 0));
        check("mem_din",  64'(bus.mem_din),  64'(m_data));
        check("last_id",  64'(last_id),      64'(m_last));
        check("wr_count", 64'(wr_count),     64'(m_count));
        check("mem_reg",  64'(mem_q),        64'(m_mem));
    endtask

    // One clock: model the edge, compare on the falling edge, then let the requesters react.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (bus.mem_wren) wren_seen++;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
                ack_seen[i]++;
                ack_log.push_back(i);
                if (auto_drop) req_v[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i] && $urandom_range(0, 3) == 0) req_v[i] = 1'b1;
                else if (req_v[i] && $urandom_range(0, 31) == 0) req_v[i] = 1'b0;
                bus.req_data[i * DW +: DW] = DW'({$urandom, $urandom});
            end
        end
        bus.req = req_v;
    endtask

    // Assert reset mid-cycle, check its asynchronous effect, hold it, then release on a falling edge.
    task automatic apply_reset(input int hold);
        #2 arst = 1'b1;
        model_reset();
        #1 check_outputs();
        repeat (hold) cycle();
        arst = 1'b0;
    endtask

    task automatic set_req(input logic [NREQ-1:0] v);
        req_v   = v;
        bus.req = v;
    endtask

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        auto_drop    = 1'b0;
        rand_mode    = 1'b0;
        req_v        = '0;
        bus.req      = '0;
        bus.req_data = '0;
        model_reset();
        clear_stats();

        // Reset values, first from power-up, then with all requests active mid-transaction.
        apply_reset(2);
        set_req(4'b1111);
        repeat (2) cycle();
        apply_reset(2);
        set_req(4'b0000);
        repeat (3) cycle();

        // Single write from requester 2.
        auto_drop = 1'b1;
        bus.req_data[2 * DW +: DW] = 35'h4_0000_0ABC;
        clear_stats();
        set_req(4'b0100);
        repeat (6) cycle();
        check("single_wren_cycles", 64'(wren_seen), 64'd1);
        check("single_ack2", 64'(ack_seen[2]), 64'd1);
        check("single_last_id", 64'(last_id), 64'd2);
        check("single_wr_count", 64'(wr_count), 64'd1);
        check("single_mem", 64'(mem_q), 64'h4_0000_0ABC);

        // Round-robin rotation with all requests held continuously.
        apply_reset(1);
        auto_drop = 1'b0;
        clear_stats();
        for (int i = 0; i < NREQ; i++) bus.req_data[i * DW +: DW] = DW'(64'h1_0000_0000 + i);
        set_req(4'b1111);
        repeat (15) cycle();
        check("rr_ack_count", 64'(ack_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < ack_log.size(); i++)
            check("rr_order", 64'(ack_log[i]), 64'(exp_order[i]));
        check("rr_wr_count", 64'(wr_count), 64'd5);
        check("rr_wren_pulses", 64'(wren_seen), 64'd5);
        set_req(4'b0000);
        repeat (3) cycle();

        // Withdrawal: requester 0 drops req during WRITE.
        apply_reset(1);
        clear_stats();
        set_req(4'b0001);
        cycle();
        set_req(4'b0000);
        repeat (5) cycle();
        check("wd_wren_pulses", 64'(wren_seen), 64'd1);
        check("wd_ack0", 64'(ack_seen[0]), 64'd1);

        // Reset during WRITE, after an earlier write has moved the pointer to 1.
        apply_reset(1);
        auto_drop = 1'b1;
        set_req(4'b0001);
        repeat (4) cycle();
        set_req(4'b0011);
        cycle();
        clear_stats();
        apply_reset(2);
        check("rst_no_ack", 64'(ack_log.size()), 64'd0);
        check("rst_mem_clear", 64'(mem_q), 64'd0);
        check("rst_count_clear", 64'(wr_count), 64'd0);
        repeat (8) cycle();
        check("rst_first_grant_present", 64'(ack_log.size() > 0), 64'd1);
        if (ack_log.size() > 0) check("rst_first_grant", 64'(ack_log[0]), 64'd0);

        // Counter saturation from 16'hFFFE.
        apply_reset(1);
        set_req(4'b0000);
        force dut.wr_count = 16'hFFFE;
        m_count = 16'hFFFE;
        cycle();
        release dut.wr_count;
        auto_drop = 1'b0;
        set_req(4'b1111);
        repeat (9) cycle();
        check("sat_count", 64'(wr_count), 64'hFFFF);
        set_req(4'b0000);
        repeat (6) cycle();
        check("sat_hold", 64'(wr_count), 64'hFFFF);

        // Randomized traffic with a reset in the middle.
        apply_reset(1);
        auto_drop = 1'b1;
        rand_mode = 1'b1;
        repeat (1500) cycle();
        apply_reset(1);
        repeat (1500) cycle();
        rand_mode = 1'b0;
        set_req(4'b0000);
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
